// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit counters for fetch prediction plus EX-side training and mispredict flag.
// Optional BTB_STATS_EN adds resolved-branch and misprediction counters.
module btb_predictor #(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_IF,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic [31:0] o_pc_next,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_jump,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  output logic        o_mispred
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] o_num_branch,
  output logic [31:0] o_num_mispred
`endif
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [31:0]            target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [IDX_W-1:0] if_idx, upd_idx;
  logic             if_hit, upd_hit, upd_we;
  logic [1:0]       ctr_d, ctr_old;
  logic [31:0]      target_d;
  logic             unused_ok;
  assign unused_ok = ^i_upd_pc[1:0];
  assign if_idx        = i_pc_IF[IDX_W+1:2];
  assign if_hit        = valid_q[if_idx] && tag_q[if_idx] == i_pc_IF[31:IDX_W+2];
  assign o_pred_taken  = if_hit & ctr_q[if_idx][1];
  assign o_pred_target = o_pred_taken ? target_q[if_idx] : 32'd0;
  assign o_pc_next     = o_pred_taken ? o_pred_target : i_pc_IF + 32'd4;
  assign o_mispred = i_upd_valid & ((i_upd_taken != i_upd_pred_taken) |
                                    (i_upd_taken & (i_upd_target != i_upd_pred_target)));
  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_hit = valid_q[upd_idx] && tag_q[upd_idx] == i_upd_pc[31:IDX_W+2];
  assign upd_we  = i_upd_valid & (upd_hit | i_upd_taken);
  assign ctr_old = ctr_q[upd_idx];
  // Misses allocate with a taken-biased counter; hits saturate toward the outcome.
  always_comb begin
    ctr_d    = !upd_hit ? (i_upd_jump ? 2'b11 : 2'b10)
             : i_upd_jump ? 2'b11
             : i_upd_taken ? (ctr_old == 2'b11 ? 2'b11 : ctr_old + 2'd1)
             : (ctr_old == 2'b00 ? 2'b00 : ctr_old - 2'd1);
    target_d = (i_upd_taken | i_upd_jump) ? i_upd_target : target_q[upd_idx];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= i_upd_pc[31:IDX_W+2];
      target_q[upd_idx] <= target_d;
      ctr_q[upd_idx]    <= ctr_d;
    end
  end
`ifdef BTB_STATS_EN
  logic [31:0] num_branch_q, num_mispred_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      num_branch_q  <= '0;
      num_mispred_q <= '0;
    end else begin
      num_branch_q  <= num_branch_q + {31'd0, i_upd_valid};
      num_mispred_q <= num_mispred_q + {31'd0, o_mispred};
    end
  end
  assign o_num_branch  = num_branch_q;
  assign o_num_mispred = num_mispred_q;
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed checks of lookup, training, aliasing, mispredict and reset behaviour.
module tb_btb_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target, pc_next;
  logic        upd_valid, upd_jump, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        mispred;
  int          n_cmp = 0, n_err = 0;
`ifdef BTB_STATS_EN
  logic [31:0] num_branch, num_mispred;
`endif
  always #5 clk = ~clk;
  btb_predictor #(.BTB_ENTRIES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pc_IF(pc_if),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target), .o_pc_next(pc_next),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_jump(upd_jump),
    .i_upd_taken(upd_taken), .i_upd_target(upd_target),
    .i_upd_pred_taken(upd_pred_taken), .i_upd_pred_target(upd_pred_target),
    .o_mispred(mispred)
`ifdef BTB_STATS_EN
    , .o_num_branch(num_branch), .o_num_mispred(num_mispred)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_upd(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
    upd_valid = 1'b1; upd_pc = pc; upd_jump = j; upd_taken = t; upd_target = tgt;
    upd_pred_taken = pt; upd_pred_target = ptgt;
    #1;
  endtask
  task automatic fire(input logic [31:0] pc, input logic j, input logic t, input logic [31:0] tgt,
                      input logic pt, input logic [31:0] ptgt);
    set_upd(pc, j, t, tgt, pt, ptgt);
    tick();
    upd_valid = 1'b0;
    #1;
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic exp_t, input logic [31:0] exp_tgt);
    pc_if = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    chk({tag, "_target"}, pred_target, exp_t ? exp_tgt : 32'd0);
    chk({tag, "_next"}, pc_next, exp_t ? exp_tgt : pc + 32'd4);
  endtask
  initial begin
    rst_n = 1'b0; pc_if = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_jump = 1'b0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    set_upd(32'h100, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
    chk("mispred_in_reset", {31'd0, mispred}, 32'd1);
    tick(); tick();
    rst_n = 1'b1; upd_valid = 1'b0;
    #1;
    look("reset_empty", 32'h100, 1'b0, 32'h0);
    set_upd(32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("mispred_new_taken", {31'd0, mispred}, 32'd1);
    look("same_cycle_old", 32'h100, 1'b0, 32'h0);
    tick(); upd_valid = 1'b0;
    look("alloc_branch", 32'h100, 1'b1, 32'h40);
    set_upd(32'h100, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
    chk("mispred_nt", {31'd0, mispred}, 32'd1);
    tick(); upd_valid = 1'b0;
    look("ctr_01", 32'h100, 1'b0, 32'h0);
    fire(32'h100, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
    look("ctr_10", 32'h100, 1'b1, 32'h40);
    fire(32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40);
    for (int i = 0; i < 4; i++) begin
      fire(32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40);
      look("ctr_sat", 32'h100, 1'b1, 32'h40);
    end
    fire(32'h100, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
    look("sat_then_nt", 32'h100, 1'b1, 32'h40);
    fire(32'h100, 1'b0, 1'b0, 32'h40, 1'b1, 32'h40);
    look("second_nt", 32'h100, 1'b0, 32'h0);
    set_upd(32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h44);
    chk("mispred_wrong_tgt", {31'd0, mispred}, 32'd1);
    set_upd(32'h100, 1'b0, 1'b1, 32'h40, 1'b1, 32'h40);
    chk("correct_taken", {31'd0, mispred}, 32'd0);
    set_upd(32'h100, 1'b0, 1'b0, 32'h40, 1'b0, 32'h44);
    chk("correct_nt", {31'd0, mispred}, 32'd0);
    upd_valid = 1'b0; upd_taken = 1'b1;
    #1;
    chk("no_valid", {31'd0, mispred}, 32'd0);
    look("jump_pre_miss", 32'h200, 1'b0, 32'h0);
    fire(32'h200, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    look("jump_alloc", 32'h200, 1'b1, 32'h80);
    look("evicted_100", 32'h100, 1'b0, 32'h0);
    fire(32'h200, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    look("jump_ctr11", 32'h200, 1'b1, 32'h80);
    fire(32'h240, 1'b0, 1'b1, 32'hC0, 1'b0, 32'h0);
    look("alias_old", 32'h200, 1'b0, 32'h0);
    look("alias_new", 32'h240, 1'b1, 32'hC0);
    fire(32'h280, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    look("miss_nt_keep", 32'h240, 1'b1, 32'hC0);
    look("miss_nt_noalloc", 32'h280, 1'b0, 32'h0);
    fire(32'h244, 1'b0, 1'b1, 32'h1234, 1'b0, 32'h0);
    look("idx1_entry", 32'h244, 1'b1, 32'h1234);
    look("idx1_keeps_idx0", 32'h240, 1'b1, 32'hC0);
    rst_n = 1'b0;
    fire(32'h240, 1'b1, 1'b1, 32'hC0, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    look("reset_clears", 32'h240, 1'b0, 32'h0);
    look("reset_drop_upd", 32'h244, 1'b0, 32'h0);
`ifdef BTB_STATS_EN
    chk("stats_rst_br", num_branch, 32'd0);
    chk("stats_rst_mp", num_mispred, 32'd0);
    for (int i = 0; i < 10; i++)
      fire(32'h300, 1'b0, 1'b1, 32'h600, 1'b1, (i < 3) ? 32'h0 : 32'h600);
    chk("stats_branch", num_branch, 32'd10);
    chk("stats_mispred", num_mispred, 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("stats_clr_br", num_branch, 32'd0);
    chk("stats_clr_mp", num_mispred, 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
